// File: rtl/mcb_ini_cmd_issue.sv
// Init-command issuer: turns init-controller request strobes into single SDRAM
// command cycles, pads tRP/tRFC/tMRD with NOPs, and flags protocol misuse.
module mcb_ini_cmd_issue #(
  parameter int CtRP   = 3,
  parameter int CtRFC  = 8,
  parameter int CtMRD  = 2,
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2,
  parameter logic [ADDR_W-1:0] MODE_REG = 'h032
) (
  input  logic              mcb_clk,
  input  logic              mcb_rst,
  input  logic              i_prea,
  input  logic              i_ref,
  input  logic              i_lmr,
  input  logic              i_ready,
  output logic              ini_ack,
  output logic              ini_busy,
  output logic              ini_done,
  output logic              ini_err,
  output logic              sd_cke,
  output logic              sd_cs_n,
  output logic              sd_ras_n,
  output logic              sd_cas_n,
  output logic              sd_we_n,
  output logic [BA_W-1:0]   sd_ba,
  output logic [ADDR_W-1:0] sd_addr
);

  typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_t;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PREA = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;

  state_t     state;
  logic [7:0] cnt;
  logic       ready_pend;
  logic [3:0] cmd_pins;
  logic       any_req;
  logic       multi_req;

  assign any_req   = i_prea | i_ref | i_lmr;
  assign multi_req = (i_prea & i_ref) | (i_prea & i_lmr) | (i_ref & i_lmr);

  assign sd_cs_n  = cmd_pins[3];
  assign sd_ras_n = cmd_pins[2];
  assign sd_cas_n = cmd_pins[1];
  assign sd_we_n  = cmd_pins[0];

  // Counter holds the remaining busy cycles after the current one; the window
  // closes on the edge where it reads zero, so T=1 skips WAIT entirely.
  always_ff @(posedge mcb_clk) begin
    if (mcb_rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      ready_pend <= 1'b0;
      cmd_pins   <= CMD_NOP;
      sd_ba      <= '0;
      sd_addr    <= '0;
      sd_cke     <= 1'b0;
      ini_ack    <= 1'b0;
      ini_busy   <= 1'b0;
      ini_done   <= 1'b0;
      ini_err    <= 1'b0;
    end else begin
      sd_cke   <= 1'b1;
      ini_ack  <= 1'b0;
      cmd_pins <= CMD_NOP;
      sd_ba    <= '0;
      sd_addr  <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= CMD;
            ini_ack    <= 1'b1;
            ini_busy   <= 1'b1;
            ready_pend <= i_ready;
            if (multi_req) ini_err <= 1'b1;
            if (i_prea) begin
              cmd_pins    <= CMD_PREA;
              sd_addr[10] <= 1'b1;
              cnt         <= 8'(CtRP - 1);
            end else if (i_ref) begin
              cmd_pins <= CMD_REF;
              cnt      <= 8'(CtRFC - 1);
            end else begin
              cmd_pins <= CMD_LMR;
              sd_addr  <= MODE_REG;
              cnt      <= 8'(CtMRD - 1);
            end
          end else if (i_ready) begin
            state    <= DONE;
            ini_done <= 1'b1;
          end
        end
        CMD, WAIT: begin
          if (any_req) ini_err <= 1'b1;
          if (cnt == 8'd0) begin
            ini_busy   <= 1'b0;
            ready_pend <= 1'b0;
            if (ready_pend | i_ready) begin
              state    <= DONE;
              ini_done <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt        <= cnt - 8'd1;
            state      <= WAIT;
            ready_pend <= ready_pend | i_ready;
          end
        end
        default: begin
          if (any_req) ini_err <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcb_ini_cmd_issue.sv
// Directed self-checking bench for mcb_ini_cmd_issue with default timing
// parameters (tRP=3, tRFC=8, tMRD=2, MODE_REG=13'h032).
module tb_mcb_ini_cmd_issue;

  logic        mcb_clk = 1'b0;
  logic        mcb_rst = 1'b1;
  logic        i_prea = 1'b0, i_ref = 1'b0, i_lmr = 1'b0, i_ready = 1'b0;
  logic        ini_ack, ini_busy, ini_done, ini_err;
  logic        sd_cke, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n;
  logic [1:0]  sd_ba;
  logic [12:0] sd_addr;

  int errors = 0;
  int checks = 0;

  always #5 mcb_clk = ~mcb_clk;

  mcb_ini_cmd_issue dut (
    .mcb_clk(mcb_clk), .mcb_rst(mcb_rst),
    .i_prea(i_prea), .i_ref(i_ref), .i_lmr(i_lmr), .i_ready(i_ready),
    .ini_ack(ini_ack), .ini_busy(ini_busy), .ini_done(ini_done), .ini_err(ini_err),
    .sd_cke(sd_cke), .sd_cs_n(sd_cs_n), .sd_ras_n(sd_ras_n),
    .sd_cas_n(sd_cas_n), .sd_we_n(sd_we_n), .sd_ba(sd_ba), .sd_addr(sd_addr)
  );

  // Advance into the next cycle and settle away from the clock edge.
  task automatic step();
    @(posedge mcb_clk);
    #1;
  endtask

  task automatic do_reset();
    mcb_rst = 1'b1;
    step();
    step();
    mcb_rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    mcb_rst = 1'b1;
    step(); step(); step();
    checks++;
    if ({sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, sd_cke} !== 5'b01110) begin
      errors++;
      $display("[TB] FAIL reset_pins got=%b exp=01110",
               {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, sd_cke});
    end
    checks++;
    if ({ini_ack, ini_busy, ini_done, ini_err, sd_ba, sd_addr} !== 19'd0) begin
      errors++;
      $display("[TB] FAIL reset_flags got=%b exp=0",
               {ini_ack, ini_busy, ini_done, ini_err, sd_ba, sd_addr});
    end
    mcb_rst = 1'b0;
    step();
    checks++;
    if ({sd_cke, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} !== 5'b10111) begin
      errors++;
      $display("[TB] FAIL cke_rise got=%b exp=10111",
               {sd_cke, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n});
    end
  endtask

  task automatic test_prea_then_ref();
    i_prea = 1'b1;
    step();
    i_prea = 1'b0;
    checks++;
    if ({sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, ini_ack, ini_busy, sd_ba, sd_addr} !==
        {4'b0010, 1'b1, 1'b1, 2'b00, 13'h400}) begin
      errors++;
      $display("[TB] FAIL prea_issue got=%b exp=%b",
               {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, ini_ack, ini_busy, sd_ba, sd_addr},
               {4'b0010, 1'b1, 1'b1, 2'b00, 13'h400});
    end
    step();
    checks++;
    if ({sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, ini_ack, ini_busy} !== 6'b011101) begin
      errors++;
      $display("[TB] FAIL prea_wait1 got=%b exp=011101",
               {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, ini_ack, ini_busy});
    end
    step();
    checks++;
    if (ini_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL prea_wait2_busy got=%b exp=1", ini_busy);
    end
    step();
    checks++;
    if (ini_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prea_busy_fall got=%b exp=0", ini_busy);
    end
    i_ref = 1'b1;
    step();
    i_ref = 1'b0;
    checks++;
    if ({sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, ini_ack, ini_busy, sd_addr} !==
        {4'b0001, 1'b1, 1'b1, 13'h000}) begin
      errors++;
      $display("[TB] FAIL ref_after_prea got=%b exp=%b",
               {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, ini_ack, ini_busy, sd_addr},
               {4'b0001, 1'b1, 1'b1, 13'h000});
    end
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (ini_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ref_last_busy got=%b exp=1", ini_busy);
    end
    step();
    checks++;
    if ({ini_busy, ini_err} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL ref_end got=%b exp=00", {ini_busy, ini_err});
    end
  endtask

  task automatic test_lmr();
    i_lmr = 1'b1;
    step();
    i_lmr = 1'b0;
    checks++;
    if ({sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, ini_ack, sd_ba, sd_addr} !==
        {4'b0000, 1'b1, 2'b00, 13'h032}) begin
      errors++;
      $display("[TB] FAIL lmr_issue got=%b exp=%b",
               {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, ini_ack, sd_ba, sd_addr},
               {4'b0000, 1'b1, 2'b00, 13'h032});
    end
    step();
    checks++;
    if ({ini_busy, ini_ack} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL lmr_busy2 got=%b exp=10", {ini_busy, ini_ack});
    end
    step();
    checks++;
    if ({ini_busy, ini_err} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL lmr_end got=%b exp=00", {ini_busy, ini_err});
    end
  endtask

  task automatic test_req_while_busy();
    do_reset();
    i_ref = 1'b1;
    step();
    i_ref = 1'b0;
    step();
    i_prea = 1'b1;
    step();
    i_prea = 1'b0;
    checks++;
    if ({ini_err, ini_ack, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, ini_busy} !== 7'b1001111) begin
      errors++;
      $display("[TB] FAIL busy_drop got=%b exp=1001111",
               {ini_err, ini_ack, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, ini_busy});
    end
    for (int i = 0; i < 5; i++) step();
    checks++;
    if ({ini_busy, ini_ack} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL busy_drop_window got=%b exp=10", {ini_busy, ini_ack});
    end
    step();
    checks++;
    if (ini_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_drop_end got=%b exp=0", ini_busy);
    end
  endtask

  task automatic test_priority_and_ready();
    do_reset();
    i_prea = 1'b1;
    i_lmr  = 1'b1;
    step();
    i_prea = 1'b0;
    i_lmr  = 1'b0;
    checks++;
    if ({sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, ini_ack, ini_err, sd_addr} !==
        {4'b0010, 1'b1, 1'b1, 13'h400}) begin
      errors++;
      $display("[TB] FAIL multi_req got=%b exp=%b",
               {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, ini_ack, ini_err, sd_addr},
               {4'b0010, 1'b1, 1'b1, 13'h400});
    end
    step();
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    checks++;
    if ({ini_busy, ini_done} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL ready_latched got=%b exp=10", {ini_busy, ini_done});
    end
    step();
    checks++;
    if ({ini_busy, ini_done} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL ready_done got=%b exp=01", {ini_busy, ini_done});
    end
    step();
    checks++;
    if ({sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, ini_ack, ini_done} !== 6'b011101) begin
      errors++;
      $display("[TB] FAIL no_lmr_later got=%b exp=011101",
               {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, ini_ack, ini_done});
    end
  endtask

  task automatic test_done_state();
    do_reset();
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    checks++;
    if ({ini_done, ini_busy, ini_err} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL ready_idle got=%b exp=100", {ini_done, ini_busy, ini_err});
    end
    i_ref = 1'b1;
    step();
    i_ref = 1'b0;
    checks++;
    if ({ini_err, ini_ack, ini_busy, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} !== 7'b1000111) begin
      errors++;
      $display("[TB] FAIL done_ignore got=%b exp=1000111",
               {ini_err, ini_ack, ini_busy, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n});
    end
  endtask

  task automatic test_reset_mid_window();
    do_reset();
    i_ref = 1'b1;
    step();
    i_ref = 1'b0;
    step();
    mcb_rst = 1'b1;
    step();
    checks++;
    if ({sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, ini_busy, sd_cke, ini_ack} !== 7'b0111000) begin
      errors++;
      $display("[TB] FAIL rst_mid got=%b exp=0111000",
               {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, ini_busy, sd_cke, ini_ack});
    end
    mcb_rst = 1'b0;
    step();
    i_prea = 1'b1;
    step();
    i_prea = 1'b0;
    checks++;
    if ({sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, ini_ack, ini_busy, sd_cke, ini_err} !== 8'b00101110) begin
      errors++;
      $display("[TB] FAIL rst_then_prea got=%b exp=00101110",
               {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, ini_ack, ini_busy, sd_cke, ini_err});
    end
  endtask

  initial begin
    test_reset();
    test_prea_then_ref();
    test_lmr();
    test_req_while_busy();
    test_priority_and_ready();
    test_done_state();
    test_reset_mid_window();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
